// File: rtl/ah_lru_arbiter_n.sv
// rtl/ah_lru_arbiter_n.sv - parametrised LRU arbiter with registered one-hot grant and busy hold
// Define AH_LRU_ARB_LOCK_EN to add the lock port and locked multi-cycle ownership.
module ah_lru_arbiter_n #(
  parameter  int N  = 10,
  localparam int RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          gnt_busy,
`ifdef AH_LRU_ARB_LOCK_EN
  input  logic          lock,
`endif
  output logic [N-1:0]  gnt,
  output logic          gnt_vld,
  output logic [RW-1:0] gnt_id
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            gnt_vld_q, gnt_vld_d;
  logic [RW-1:0]   gnt_id_q, gnt_id_d;
  logic [RW-1:0]   rank_q [N];
  logic [RW-1:0]   rank_d [N];

  logic            win_found;
  logic [RW-1:0]   win_idx;
  logic [RW-1:0]   win_rank;
  logic            lock_hold;
  logic            issue;

  // Ranks are unique, so the strict less-than comparison never has to break a tie.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_rank  = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (!win_found || rank_q[i] < win_rank)) begin
        win_found = 1'b1;
        win_idx   = RW'(i);
        win_rank  = rank_q[i];
      end
    end
  end

`ifdef AH_LRU_ARB_LOCK_EN
  assign lock_hold = (state_q == S_GRANT) && lock && |(req & gnt_q);
`else
  assign lock_hold = 1'b0;
`endif

  // Busy outranks lock; either one freezes both the grant and the rank table.
  assign issue = !gnt_busy && !lock_hold && win_found;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_vld_d = gnt_vld_q;
    gnt_id_d  = gnt_id_q;
    for (int j = 0; j < N; j++) begin
      rank_d[j] = rank_q[j];
    end

    if (issue) begin
      state_d   = S_GRANT;
      gnt_d     = '0;
      gnt_d[win_idx] = 1'b1;
      gnt_vld_d = 1'b1;
      gnt_id_d  = win_idx;
      for (int j = 0; j < N; j++) begin
        if (RW'(j) == win_idx) begin
          rank_d[j] = RW'(N - 1);
        end else if (rank_q[j] > win_rank) begin
          rank_d[j] = rank_q[j] - 1'b1;
        end
      end
    end else if (!gnt_busy && !lock_hold) begin
      state_d   = S_IDLE;
      gnt_d     = '0;
      gnt_vld_d = 1'b0;
      gnt_id_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_id_q  <= '0;
      for (int i = 0; i < N; i++) begin
        rank_q[i] <= RW'(i);
      end
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_id_q  <= gnt_id_d;
      for (int i = 0; i < N; i++) begin
        rank_q[i] <= rank_d[i];
      end
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_id  = gnt_id_q;

endmodule

// File: tb/tb_ah_lru_arbiter_n.sv
// tb/tb_ah_lru_arbiter_n.sv - scoreboard bench for ah_lru_arbiter_n against an LRU-queue model
module tb_ah_lru_arbiter_n;

  localparam int N  = 4;
  localparam int RW = $clog2(N);

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req;
  logic          gnt_busy;
  logic          lock;
  logic [N-1:0]  gnt;
  logic          gnt_vld;
  logic [RW-1:0] gnt_id;

  always #5 clk = ~clk;

  ah_lru_arbiter_n #(.N(N)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .gnt_busy (gnt_busy),
`ifdef AH_LRU_ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          vld;
    logic [RW-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model: a list ordered from least to most recently granted.
  int   order[$];
  bit   m_vld;
  int   m_id;
  bit   lock_en;

  task automatic model_step(input logic r_n, input logic [N-1:0] r,
                            input logic busy, input logic lk);
    exp_t e;
    if (!r_n) begin
      order.delete();
      for (int i = 0; i < N; i++) order.push_back(i);
      m_vld = 0;
      m_id  = 0;
    end else if (busy) begin
      // hold whatever is current
    end else if (lock_en && lk && m_vld && r[m_id]) begin
      // locked holder keeps grant
    end else if (r != '0) begin
      for (int k = 0; k < order.size(); k++) begin
        if (r[order[k]]) begin
          m_id  = order[k];
          m_vld = 1;
          order.delete(k);
          order.push_back(m_id);
          break;
        end
      end
    end else begin
      m_vld = 0;
      m_id  = 0;
    end
    e.vld = m_vld;
    e.id  = RW'(m_id);
    e.gnt = m_vld ? (N'(1) << m_id) : '0;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic r_n, input logic [N-1:0] r,
                       input logic busy, input logic lk);
    @(negedge clk);
    rstn     = r_n;
    req      = r;
    gnt_busy = busy;
    lock     = lk;
    model_step(r_n, r, busy, lk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cyc++;
        checks++;
        if (gnt !== e.gnt || gnt_vld !== e.vld || gnt_id !== e.id) begin
          errors++;
          $display("FAIL grant cyc %0d: got gnt=%b vld=%b id=%0d, expected gnt=%b vld=%b id=%0d",
                   cyc, gnt, gnt_vld, gnt_id, e.gnt, e.vld, e.id);
        end
      end
    end
  end

  initial begin : stim
`ifdef AH_LRU_ARB_LOCK_EN
    lock_en = 1;
`else
    lock_en = 0;
`endif
    rstn = 1'b0; req = '0; gnt_busy = 1'b0; lock = 1'b0;
    for (int i = 0; i < N; i++) order.push_back(i);
    m_vld = 0; m_id = 0;

    cycle(0, 4'b0000, 0, 0);
    // round-robin from reset
    for (int i = 0; i < 5; i++) cycle(1, 4'b1111, 0, 0);
    // LRU alternation
    cycle(0, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 4'b0101, 0, 0);
    // busy hold with holder dropping req
    cycle(0, 4'b0000, 0, 0);
    cycle(1, 4'b0010, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 4'b0000, 1, 0);
    cycle(1, 4'b0000, 0, 0);
    // busy in idle
    for (int i = 0; i < 5; i++) cycle(1, 4'b1000, 1, 0);
    cycle(1, 4'b1000, 0, 0);
    cycle(1, 4'b0000, 0, 0);
    // lock hold
    cycle(0, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 4'b0011, 0, 1);
    cycle(1, 4'b0011, 0, 0);
    // reset mid-grant
    cycle(1, 4'b1111, 0, 0);
    cycle(1, 4'b1111, 0, 0);
    cycle(0, 4'b1111, 0, 0);
    cycle(1, 4'b1111, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 63) != 0), N'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    @(negedge clk);
    rstn = 1'b1; req = '0; gnt_busy = 1'b0; lock = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
